// File: rtl/button_pkg.sv
// Shared definitions for the multi-channel button debouncer: per-channel FSM
// encoding, default parameter values and a constant-foldable clog2.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } ch_state_t;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_LONG_CYCLES     = 64;
    localparam bit DEF_ACTIVE_LOW      = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter that toggles the
// debounced level, and an IDLE/PRESSED/LONG FSM producing one-cycle strobes.
module debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int   CNT_W        = clog2(DEBOUNCE_CYCLES + 1);
    localparam int   HOLD_W       = clog2(LONG_CYCLES + 1);
    localparam logic RELEASED_RAW = ACTIVE_LOW;

    logic              sync1_reg;
    logic              sync2_reg;
    logic              sample;
    logic [CNT_W-1:0]  cnt_reg;
    logic              level_reg;
    logic              accept;
    logic              rise;
    logic              fall;
    ch_state_t         state_reg;
    ch_state_t         state_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [HOLD_W-1:0] hold_next;
    logic              press_reg;
    logic              press_next;
    logic              release_reg;
    logic              release_next;
    logic              long_reg;
    logic              long_next;

    // Synchroniser resets to the idle (released) raw level so a held button
    // is seen as a fresh transition once reset lifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= RELEASED_RAW;
            sync2_reg <= RELEASED_RAW;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
        end
    end

    assign sample = sync2_reg ^ RELEASED_RAW;

    // The edge that would take the counter to DEBOUNCE_CYCLES toggles instead.
    assign accept = (sample != level_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept & ~level_reg;
    assign fall   = accept & level_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (sample == level_reg) begin
            cnt_reg   <= '0;
        end else if (accept) begin
            cnt_reg   <= '0;
            level_reg <= ~level_reg;
        end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            hold_reg    <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            long_reg    <= long_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rise) state_next = PRESSED;
            end
            PRESSED: begin
                if (fall)
                    state_next = IDLE;
                else if (hold_reg == HOLD_W'(LONG_CYCLES - 1))
                    state_next = LONG;
            end
            LONG: begin
                if (fall) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered together with level so they line up with it.
    always_comb begin
        hold_next    = hold_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                hold_next  = '0;
                press_next = rise;
            end
            PRESSED: begin
                release_next = fall;
                if (hold_reg != HOLD_W'(LONG_CYCLES))
                    hold_next = hold_reg + HOLD_W'(1);
                long_next = ~fall && (hold_reg == HOLD_W'(LONG_CYCLES - 1));
            end
            LONG: begin
                release_next = fall;
            end
            default: hold_next = '0;
        endcase
    end

    assign level         = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign long_pulse    = long_reg;

endmodule

// File: rtl/button_debounce_multi.sv
// Bank of CHANNELS independent debounced buttons with press, release and
// long-press strobes.
module button_debounce_multi
    import button_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_ch (
                .clk           (clk),
                .rst           (rst),
                .button        (button[gi]),
                .level         (level[gi]),
                .press_pulse   (press_pulse[gi]),
                .release_pulse (release_pulse[gi]),
                .long_pulse    (long_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: a run-length reference model fills a
// scoreboard checked every cycle, plus fixed-latency checks for key scenarios.
module tb_button_debounce_multi;

    localparam int CH   = 4;
    localparam int DEB  = 16;
    localparam int LONG = 64;
    localparam bit AL   = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] button = '1;
    logic [CH-1:0] level;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] long_pulse;

    always #5 clk = ~clk;

    button_debounce_multi #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .ACTIVE_LOW      (AL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] prs;
        logic [CH-1:0] rls;
        logic [CH-1:0] lng;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: raw values reach the decision two edges late; a level
    // flips once DEB consecutive delayed samples, all taken since the last
    // flip, disagree with it.
    int   edge_n = 0;
    bit   pipe_q[CH][$];
    bit   samp_q[CH][$];
    bit   m_level[CH];
    int   last_toggle[CH];
    int   press_edge[CH];
    bit   long_done[CH];

    task automatic model_edge();
        exp_t e;
        e = '0;
        edge_n++;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                pipe_q[c].delete();
                pipe_q[c].push_back(1'b0);
                pipe_q[c].push_back(1'b0);
                samp_q[c].delete();
                m_level[c]     = 1'b0;
                last_toggle[c] = edge_n;
                long_done[c]   = 1'b1;
            end else begin
                bit used;
                bit stable;
                used = pipe_q[c].pop_front();
                pipe_q[c].push_back(AL ? ~button[c] : button[c]);
                samp_q[c].push_back(used);
                if (samp_q[c].size() > DEB) void'(samp_q[c].pop_front());
                stable = (samp_q[c].size() == DEB) && (edge_n - last_toggle[c] >= DEB);
                for (int i = 0; i < samp_q[c].size(); i++)
                    if (samp_q[c][i] == m_level[c]) stable = 1'b0;
                if (stable) begin
                    m_level[c]     = ~m_level[c];
                    last_toggle[c] = edge_n;
                    if (m_level[c]) begin
                        e.prs[c]      = 1'b1;
                        press_edge[c] = edge_n;
                        long_done[c]  = 1'b0;
                    end else begin
                        e.rls[c] = 1'b1;
                    end
                end else if (m_level[c] && !long_done[c] && (edge_n - press_edge[c] == LONG)) begin
                    e.lng[c]     = 1'b1;
                    long_done[c] = 1'b1;
                end
            end
            e.lvl[c] = m_level[c];
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic dchk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 4;
                if (level !== e.lvl) begin
                    failures++;
                    $display("FAIL sb_level edge=%0d: got %b expected %b", edge_n, level, e.lvl);
                end
                if (press_pulse !== e.prs) begin
                    failures++;
                    $display("FAIL sb_press edge=%0d: got %b expected %b", edge_n, press_pulse, e.prs);
                end
                if (release_pulse !== e.rls) begin
                    failures++;
                    $display("FAIL sb_release edge=%0d: got %b expected %b", edge_n, release_pulse, e.rls);
                end
                if (long_pulse !== e.lng) begin
                    failures++;
                    $display("FAIL sb_long edge=%0d: got %b expected %b", edge_n, long_pulse, e.lng);
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] acc;
        int            rem[CH];

        // Reset state and first cycle after reset
        run(3);
        dchk("reset_outputs", level | press_pulse | release_pulse | long_pulse, '0);
        rst = 1'b0;
        tick();
        dchk("no_pulse_after_reset", press_pulse | release_pulse | long_pulse, '0);
        run(5);
        $display("scenario reset done");

        // Clean press on channel 0 with long press and release
        button[0] = 1'b0;
        run(17);
        dchk("clean_level_edge17", level, 4'b0000);
        tick();
        dchk("clean_level_edge18", level, 4'b0001);
        dchk("clean_press_edge18", press_pulse, 4'b0001);
        acc = '0;
        for (int i = 0; i < 63; i++) begin
            tick();
            acc |= long_pulse | press_pulse;
        end
        dchk("clean_no_early_long", acc, 4'b0000);
        tick();
        dchk("clean_long_at_64", long_pulse, 4'b0001);
        acc = '0;
        for (int i = 0; i < 38; i++) begin
            tick();
            acc |= long_pulse;
        end
        dchk("clean_long_once", acc, 4'b0000);
        button[0] = 1'b1;
        run(17);
        dchk("clean_release_edge17", release_pulse, 4'b0000);
        tick();
        dchk("clean_release_edge18", release_pulse, 4'b0001);
        dchk("clean_level_low", level, 4'b0000);
        run(30);
        $display("scenario clean_press done");

        // Bounce on channel 1
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            button[1] = ((i / 3) % 2) ? 1'b1 : 1'b0;
            tick();
            acc |= press_pulse | release_pulse | long_pulse | level;
        end
        dchk("bounce_quiet", acc, 4'b0000);
        button[1] = 1'b0;
        run(17);
        dchk("bounce_press_edge17", press_pulse, 4'b0000);
        tick();
        dchk("bounce_press_edge18", press_pulse, 4'b0010);
        button[1] = 1'b1;
        run(30);
        $display("scenario bounce done");

        // Glitch threshold on channel 2
        button[2] = 1'b0;
        acc = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            acc |= press_pulse | release_pulse | long_pulse | level;
        end
        button[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            acc |= press_pulse | release_pulse | long_pulse | level;
        end
        dchk("glitch15_quiet", acc, 4'b0000);
        button[2] = 1'b0;
        run(16);
        button[2] = 1'b1;
        run(1);
        dchk("glitch16_press_edge17", press_pulse, 4'b0000);
        tick();
        dchk("glitch16_press_edge18", press_pulse, 4'b0100);
        acc = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            acc |= long_pulse | release_pulse;
        end
        dchk("glitch16_early_quiet", acc, 4'b0000);
        tick();
        dchk("glitch16_release", release_pulse, 4'b0100);
        dchk("glitch16_no_long", long_pulse, 4'b0000);
        run(20);
        $display("scenario glitch done");

        // Simultaneous press on channels 0 and 3
        button[0] = 1'b0;
        button[3] = 1'b0;
        run(17);
        tick();
        dchk("simul_press", press_pulse, 4'b1001);
        dchk("simul_level", level, 4'b1001);
        button[0] = 1'b1;
        button[3] = 1'b1;
        run(40);
        $display("scenario simultaneous done");

        // Reset mid-hold on channel 0
        button[0] = 1'b0;
        run(30);
        rst = 1'b1;
        tick();
        dchk("midrst_outputs_1", level | press_pulse | release_pulse | long_pulse, '0);
        tick();
        dchk("midrst_outputs_2", level | press_pulse | release_pulse | long_pulse, '0);
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 17; i++) begin
            tick();
            acc |= press_pulse | release_pulse | long_pulse;
        end
        dchk("midrst_quiet", acc, 4'b0000);
        tick();
        dchk("midrst_repress", press_pulse, 4'b0001);
        button[0] = 1'b1;
        run(40);
        $display("scenario reset_mid_hold done");

        // Randomised traffic on all channels, with occasional resets
        for (int c = 0; c < CH; c++) rem[c] = $urandom_range(1, 30);
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    button[c] = ~button[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 110))
                                                          : int'($urandom_range(1, 18));
                end
            end
            rst = ($urandom_range(0, 899) == 0);
            tick();
        end
        rst = 1'b0;
        run(5);
        $display("scenario random done");

        @(negedge clk);
        #1;
        dchk("scoreboard_drained", CH'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce_multi.md
BUTTON_DEBOUNCE_MULTI -- requirements
Module: button_debounce_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a level change; minimum 2.
REQ-003 Parameter LONG_CYCLES, default 64: cycles a channel must be held pressed before it reports a long press; must exceed DEBOUNCE_CYCLES.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means the raw input reads 0 when pressed; 0 means it reads 1 when pressed.
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 button  input  CHANNELS  raw, asynchronous, bouncy button inputs.
REQ-008 level  output  CHANNELS  debounced pressed state per channel; 1 means pressed.
REQ-009 press_pulse  output  CHANNELS  one-cycle strobe on an accepted press.
REQ-010 release_pulse  output  CHANNELS  one-cycle strobe on an accepted release.
REQ-011 long_pulse  output  CHANNELS  one-cycle strobe when a press reaches LONG_CYCLES.

Function
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchroniser and then apply ACTIVE_LOW polarity correction; the synchronised value is called "sample".
REQ-013 Each channel SHALL keep a debounce counter of width clog2(DEBOUNCE_CYCLES+1). The counter increments while sample differs from level, and clears to 0 in any cycle where sample equals level.
REQ-014 When the counter reaches DEBOUNCE_CYCLES, level SHALL toggle and the counter SHALL clear in the same edge.
REQ-015 A raw change held steady SHALL appear on level at rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new value as edge 1.
REQ-016 Any bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave level, the pulses and the channel state unchanged.
REQ-017 Each channel SHALL run an FSM with states IDLE, PRESSED and LONG:
  - IDLE -> PRESSED when level rises; press_pulse asserts in the same cycle level first reads 1.
  - PRESSED -> LONG when the hold counter reaches LONG_CYCLES; long_pulse asserts for one cycle.
  - PRESSED or LONG -> IDLE when level falls; release_pulse asserts in the same cycle level first reads 0.
REQ-018 The hold counter SHALL clear on press, increment each cycle in PRESSED, saturate at LONG_CYCLES, and hold its value in LONG.
REQ-019 long_pulse SHALL assert on the LONG_CYCLES-th cycle after the press_pulse cycle.
REQ-020 long_pulse SHALL fire at most once per press.
REQ-021 A release before LONG_CYCLES SHALL produce release_pulse only, with no long_pulse.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL assert their pulses in the same cycle.
REQ-023 press_pulse, release_pulse and long_pulse SHALL never be asserted together on the same channel.

Reset
REQ-024 While rst is high at a rising edge, the synchronisers SHALL load the released value, the counters SHALL load 0 and every FSM SHALL load IDLE.
REQ-025 Reset values SHALL be: level = 0, press_pulse = 0, release_pulse = 0, long_pulse = 0.
REQ-026 No pulse SHALL assert in the first cycle after rst deasserts.
REQ-027 Reset asserted mid-operation SHALL abort the operation without a release_pulse.
REQ-028 A button still held after reset SHALL be debounced afresh as a new press.

Structure
REQ-029 Package button_pkg SHALL hold the FSM state encoding (IDLE, PRESSED, LONG), the parameter defaults and a clog2 helper.
REQ-030 Per-channel logic (synchroniser, debounce counter, hold counter, FSM) SHALL live in sub-module debounce_ch; the top level instantiates CHANNELS copies in a generate loop.

Verification (CHANNELS=4, DEBOUNCE_CYCLES=16, LONG_CYCLES=64, ACTIVE_LOW=1)
REQ-031 Clean press: button[0] driven 0 for 120 cycles, then 1.
  - level[0] rises at edge 18 and press_pulse[0] asserts for 1 cycle.
  - long_pulse[0] asserts 64 cycles after press_pulse[0], exactly once.
  - release_pulse[0] asserts at edge 18 after button[0] returns to 1.
REQ-032 Bounce: button[1] toggles every 3 cycles for 40 cycles, then is held 0.
  - No pulses during the toggling.
  - A single press_pulse[1] at edge 18 after the toggling ends.
REQ-033 Glitch threshold:
  - A 15-cycle low glitch on button[2] leaves all outputs at 0.
  - A 16-cycle low glitch produces press_pulse[2] and, 18 cycles after the input returns high, release_pulse[2], with no long_pulse[2].
REQ-034 Simultaneous press: button[0] and button[3] fall on the same edge; press_pulse[0] and press_pulse[3] assert in the same cycle, and channels 1 and 2 stay 0.
REQ-035 Reset mid-hold: rst is pulsed for 2 cycles, 30 cycles into a hold on button[0], with button[0] kept low.
  - All outputs are 0 during reset and no release_pulse appears.
  - press_pulse[0] asserts at edge 18 after rst deasserts.
